axi_instr_mem_slave: RTL and testbench

//  Read-only AXI4 slave that services the instruction cache's line-fill bursts.

---
 rtl/axi_instr_mem_slave_if.sv | 44 ++++
 rtl/axi_instr_mem_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_instr_mem_slave.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_instr_mem_slave_if.sv
// AXI4 link between the instruction cache (master) and its backing memory (slave).
// Only the read channels carry traffic; write channels exist so the slave can hold them idle.
interface axi_inf #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) ();
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_SIZE-1:0]  araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [ID_WIDTH-1:0]   arid;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;

    logic                  awvalid;
    logic                  awready;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output awvalid, wvalid, bready,
        input  arready, rvalid, rdata, rresp, rlast, rid,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  awvalid, wvalid, bready,
        output arready, rvalid, rdata, rresp, rlast, rid,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_instr_mem_slave.sv
// Read-only AXI4 slave for instruction-cache line fills: synchronous ROM, FIXED/INCR/WRAP
// bursts at one beat per cycle through a 2-entry output skid buffer.
module axi_instr_mem_slave #(
    parameter int              ADDR_SIZE  = 32,
    parameter int              DATA_WIDTH = 32,
    parameter int              ID_WIDTH   = 4,
    parameter int              MEM_DEPTH  = 4096,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = 32'h0000_0000,
    parameter string           INIT_FILE  = ""
) (
    input  logic   i_aclk,
    input  logic   i_areset_n,
    axi_inf.slave  axi
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int LOG2B      = $clog2(BEAT_BYTES);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0]   MEM_BYTES = (ADDR_SIZE+1)'(MEM_DEPTH * BEAT_BYTES);
    localparam logic [ADDR_SIZE-1:0] BEAT_INC  = ADDR_SIZE'(BEAT_BYTES);
    localparam logic [ADDR_SIZE-1:0] BEAT_MASK = ADDR_SIZE'(BEAT_BYTES - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_STREAM = 2'b10
    } state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Whole-burst protocol error: wrong beat size, reserved burst type or illegal WRAP length.
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'(LOG2B)) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] addr,
                                                       input logic [1:0] burst,
                                                       input logic [ADDR_SIZE-1:0] mask);
        logic [ADDR_SIZE-1:0] result;
        case (burst)
            BURST_FIXED: result = addr;
            BURST_INCR:  result = addr + BEAT_INC;
            BURST_WRAP:  result = (addr & ~mask) | ((addr + BEAT_INC) & mask);
            default:     result = addr;
        endcase
        return result;
    endfunction

    state_t                state_r;
    logic                  arready_r;
    logic [ADDR_SIZE-1:0]  addr_r;
    logic [ADDR_SIZE-1:0]  mask_r;
    logic [1:0]            burst_r;
    logic                  slverr_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic [8:0]            left_r;

    logic                  p_v_r;
    logic [DATA_WIDTH-1:0] ram_q_r;
    logic [1:0]            p_resp_r;
    logic                  p_last_r;

    logic                  rvalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            rresp_r;
    logic                  rlast_r;
    logic                  sk_v_r;
    logic [DATA_WIDTH-1:0] sk_data_r;
    logic [1:0]            sk_resp_r;
    logic                  sk_last_r;

    logic                  pop_s;
    logic [1:0]            occ_s;
    logic                  issue_s;
    logic [ADDR_SIZE-1:0]  off_s;
    logic [IDX_W-1:0]      idx_s;
    logic [1:0]            beat_resp_s;
    logic [DATA_WIDTH-1:0] p_data_s;

    // Fetch scheduling: a read is issued only if its data is guaranteed a buffer slot on arrival.
    always_comb begin
        pop_s   = rvalid_r & axi.rready;
        occ_s   = 2'({1'b0, rvalid_r} + {1'b0, sk_v_r} + {1'b0, p_v_r} - {1'b0, pop_s});
        issue_s = (state_r != ST_IDLE) && (left_r != 9'd0) && (occ_s <= 2'd1);
        off_s   = addr_r - BASE_ADDR;
        idx_s   = off_s[LOG2B +: IDX_W];
        if (slverr_r) begin
            beat_resp_s = RESP_SLVERR;
        end else if ({1'b0, off_s} < MEM_BYTES) begin
            beat_resp_s = RESP_OKAY;
        end else begin
            beat_resp_s = RESP_DECERR;
        end
        if (p_resp_r == RESP_OKAY) begin
            p_data_s = ram_q_r;
        end else begin
            p_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Synchronous ROM read port; out-of-range beats read a harmless alias and are zeroed later.
    always_ff @(posedge i_aclk) begin
        if (issue_s) begin
            ram_q_r <= mem[idx_s];
        end
    end

    // Burst control FSM: accepts one AR, walks the beat addresses, returns to IDLE on the last beat.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_r   <= ST_IDLE;
            arready_r <= 1'b0;
            addr_r    <= {ADDR_SIZE{1'b0}};
            mask_r    <= {ADDR_SIZE{1'b0}};
            burst_r   <= 2'b00;
            slverr_r  <= 1'b0;
            id_r      <= {ID_WIDTH{1'b0}};
            left_r    <= 9'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (axi.arvalid && arready_r) begin
                        state_r   <= ST_FETCH;
                        arready_r <= 1'b0;
                        addr_r    <= axi.araddr & ~BEAT_MASK;
                        mask_r    <= ((ADDR_SIZE'(axi.arlen) + ADDR_SIZE'(1'b1)) << LOG2B)
                                     - ADDR_SIZE'(1'b1);
                        burst_r   <= axi.arburst;
                        slverr_r  <= burst_err(axi.arsize, axi.arburst, axi.arlen);
                        id_r      <= axi.arid;
                        left_r    <= {1'b0, axi.arlen} + 9'd1;
                    end else begin
                        arready_r <= 1'b1;
                    end
                end
                ST_FETCH, ST_STREAM: begin
                    if (issue_s) begin
                        addr_r <= next_addr(addr_r, burst_r, mask_r);
                        left_r <= left_r - 9'd1;
                    end
                    if (state_r == ST_FETCH) begin
                        state_r <= ST_STREAM;
                    end else if (pop_s && rlast_r) begin
                        state_r   <= ST_IDLE;
                        arready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    arready_r <= 1'b0;
                end
            endcase
        end
    end

    // Beat metadata travelling alongside the one-cycle RAM read.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            p_v_r    <= 1'b0;
            p_resp_r <= RESP_OKAY;
            p_last_r <= 1'b0;
        end else begin
            p_v_r    <= issue_s;
            p_resp_r <= beat_resp_s;
            p_last_r <= (left_r == 9'd1);
        end
    end

    // Output register plus skid entry; the output register is only overwritten after a handshake.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rvalid_r  <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
            rresp_r   <= RESP_OKAY;
            rlast_r   <= 1'b0;
            sk_v_r    <= 1'b0;
            sk_data_r <= {DATA_WIDTH{1'b0}};
            sk_resp_r <= RESP_OKAY;
            sk_last_r <= 1'b0;
        end else if (pop_s || !rvalid_r) begin
            if (sk_v_r) begin
                rvalid_r  <= 1'b1;
                rdata_r   <= sk_data_r;
                rresp_r   <= sk_resp_r;
                rlast_r   <= sk_last_r;
                sk_v_r    <= p_v_r;
                sk_data_r <= p_data_s;
                sk_resp_r <= p_resp_r;
                sk_last_r <= p_last_r;
            end else if (p_v_r) begin
                rvalid_r <= 1'b1;
                rdata_r  <= p_data_s;
                rresp_r  <= p_resp_r;
                rlast_r  <= p_last_r;
            end else begin
                rvalid_r <= 1'b0;
                rlast_r  <= 1'b0;
            end
        end else if (p_v_r) begin
            sk_v_r    <= 1'b1;
            sk_data_r <= p_data_s;
            sk_resp_r <= p_resp_r;
            sk_last_r <= p_last_r;
        end
    end

    assign axi.arready = arready_r;
    assign axi.rvalid  = rvalid_r;
    assign axi.rdata   = rdata_r;
    assign axi.rresp   = rresp_r;
    assign axi.rlast   = rlast_r;
    assign axi.rid     = id_r;

    assign axi.awready = 1'b0;
    assign axi.wready  = 1'b0;
    assign axi.bvalid  = 1'b0;
    assign axi.bresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_instr_mem_slave.sv
// Directed bench for axi_instr_mem_slave: INCR/WRAP/stall/boundary/error/reset bursts
// against hand-computed word indices and responses.
module tb_axi_instr_mem_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    axi_inf #(.ADDR_SIZE(32), .DATA_WIDTH(32), .ID_WIDTH(4)) axi ();

    axi_instr_mem_slave #(
        .ADDR_SIZE (32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .MEM_DEPTH (DEPTH),
        .BASE_ADDR (BASE),
        .INIT_FILE ("")
    ) dut (
        .i_aclk    (clk),
        .i_areset_n(rst_n),
        .axi       (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    logic [3:0]  got_id[$];
    int          got_cyc[$];
    int          end_cyc;

    function automatic logic [31:0] mem_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, output int hs_cyc);
        int w;
        w = 0;
        @(negedge clk);
        while (!axi.arready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ar_ready_wait", axi.arready, 1'b1);
        axi.arvalid = 1'b1;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        axi.arid    = id;
        @(posedge clk);
        #1;
        hs_cyc      = cyc;
        axi.arvalid = 1'b0;
    endtask

    // Collects beats; rready follows pat (LSB first) while rvalid is up, then stays 1.
    task automatic collect(input logic [15:0] pat, input int pat_len);
        int          p;
        logic        stalled;
        logic        seen_last;
        logic [31:0] h_data;
        logic        h_last;
        logic [3:0]  h_id;
        logic [1:0]  h_resp;
        got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete(); got_cyc.delete();
        p = 0; stalled = 1'b0; seen_last = 1'b0;
        h_data = 32'h0; h_last = 1'b0; h_id = 4'h0; h_resp = 2'b00;
        for (int c = 0; c < 80 && !seen_last; c++) begin
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", axi.rvalid, 1'b1);
                check("hold_data", axi.rdata, h_data);
                check("hold_last", axi.rlast, h_last);
                check("hold_id", axi.rid, h_id);
                check("hold_resp", axi.rresp, h_resp);
            end
            if (axi.rvalid) begin
                axi.rready = (p < pat_len) ? pat[p] : 1'b1;
                p++;
            end else begin
                axi.rready = 1'b1;
            end
            if (axi.rvalid && axi.rready) begin
                got_data.push_back(axi.rdata);
                got_resp.push_back(axi.rresp);
                got_last.push_back(axi.rlast);
                got_id.push_back(axi.rid);
                got_cyc.push_back(cyc);
                check("arready_low_in_burst", axi.arready, 1'b0);
                stalled   = 1'b0;
                seen_last = axi.rlast;
            end else if (axi.rvalid) begin
                stalled = 1'b1;
                h_data = axi.rdata; h_last = axi.rlast; h_id = axi.rid; h_resp = axi.rresp;
            end
        end
        check("burst_terminated", seen_last, 1'b1);
        @(negedge clk);
        end_cyc = cyc;
        check("rvalid_after_last", axi.rvalid, 1'b0);
        check("arready_after_last", axi.arready, 1'b1);
    endtask

    task automatic verify(input string tag, input logic [3:0] id, input int eidx[$], input int eresp[$]);
        int n;
        n = eidx.size();
        check($sformatf("%s_count", tag), got_data.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            check($sformatf("%s_resp%0d", tag, i), got_resp[i], eresp[i]);
            check($sformatf("%s_data%0d", tag, i), got_data[i],
                  (eresp[i] == 0) ? mem_word(eidx[i]) : 32'h0);
            check($sformatf("%s_last%0d", tag, i), got_last[i], (i == n - 1));
            check($sformatf("%s_id%0d", tag, i), got_id[i], id);
        end
    endtask

    initial begin
        int hs;
        int beats;
        int rv_seen;
        int eidx[$];
        int eresp[$];
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = 32'h0; axi.arlen = 8'h0; axi.arsize = 3'd2;
        axi.arburst = 2'b01; axi.arid = 4'h0; axi.rready = 1'b1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        for (int i = 0; i < DEPTH; i++) dut.mem[i] = mem_word(i);

        repeat (3) @(negedge clk);
        check("rst_arready", axi.arready, 1'b0);
        check("rst_rvalid", axi.rvalid, 1'b0);
        check("rst_rlast", axi.rlast, 1'b0);
        check("rst_rdata", axi.rdata, 32'h0);
        check("rst_rresp", axi.rresp, 2'b00);
        check("rst_rid", axi.rid, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("arready_after_release", axi.arready, 1'b1);

        // 1: INCR, latency and arready timing
        send_ar(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'h3, hs);
        collect(16'hFFFF, 0);
        eidx = '{4, 5, 6, 7}; eresp = '{0, 0, 0, 0};
        verify("t1", 4'h3, eidx, eresp);
        for (int i = 0; i < 4 && i < got_cyc.size(); i++)
            check($sformatf("t1_cyc%0d", i), got_cyc[i], hs + 2 + i);
        check("t1_arready_cyc", end_cyc, hs + 6);

        // 2: WRAP across a 32-byte window
        send_ar(BASE + 32'h38, 8'd7, 3'd2, 2'b10, 4'h9, hs);
        collect(16'hFFFF, 0);
        eidx = '{14, 15, 8, 9, 10, 11, 12, 13}; eresp = '{0, 0, 0, 0, 0, 0, 0, 0};
        verify("t2", 4'h9, eidx, eresp);

        // 3: back-pressure 1,0,0,1,0,1,1
        send_ar(BASE + 32'h20, 8'd3, 3'd2, 2'b01, 4'h5, hs);
        collect(16'b0000_0000_0110_1001, 7);
        eidx = '{8, 9, 10, 11}; eresp = '{0, 0, 0, 0};
        verify("t3", 4'h5, eidx, eresp);

        // 4: run off the end of memory
        send_ar(BASE + 32'(4 * (DEPTH - 1)), 8'd1, 3'd2, 2'b01, 4'h1, hs);
        collect(16'hFFFF, 0);
        eidx = '{DEPTH - 1, DEPTH}; eresp = '{0, 3};
        verify("t4", 4'h1, eidx, eresp);

        // 5: whole-burst SLVERR cases
        send_ar(BASE + 32'h10, 8'd3, 3'd1, 2'b01, 4'h2, hs);
        collect(16'hFFFF, 0);
        eidx = '{4, 5, 6, 7}; eresp = '{2, 2, 2, 2};
        verify("t5_size", 4'h2, eidx, eresp);
        send_ar(BASE + 32'h10, 8'd3, 3'd2, 2'b11, 4'h4, hs);
        collect(16'hFFFF, 0);
        verify("t5_burst", 4'h4, eidx, eresp);
        send_ar(BASE + 32'h10, 8'd2, 3'd2, 2'b10, 4'h6, hs);
        collect(16'hFFFF, 0);
        eidx = '{4, 5, 6}; eresp = '{2, 2, 2};
        verify("t5_wrap", 4'h6, eidx, eresp);

        // 6: reset in the middle of a burst
        send_ar(BASE, 8'd7, 3'd2, 2'b01, 4'hA, hs);
        beats = 0;
        for (int c = 0; c < 20 && rst_n; c++) begin
            @(negedge clk);
            if (axi.rvalid && beats == 2) rst_n = 1'b0;
            else if (axi.rvalid) beats++;
        end
        check("t6_reset_hit", rst_n, 1'b0);
        #1;
        check("t6_rvalid_in_reset", axi.rvalid, 1'b0);
        check("t6_arready_in_reset", axi.arready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (axi.rvalid) rv_seen++;
        end
        check("t6_no_residual", rv_seen, 0);
        check("t6_arready", axi.arready, 1'b1);
        send_ar(BASE + 32'h40, 8'd1, 3'd2, 2'b01, 4'hB, hs);
        collect(16'hFFFF, 0);
        eidx = '{16, 17}; eresp = '{0, 0};
        verify("t6_after", 4'hB, eidx, eresp);

        check("awready_idle", axi.awready, 1'b0);
        check("wready_idle", axi.wready, 1'b0);
        check("bvalid_idle", axi.bvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
